// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution weight blocks.
//   - load_state_e : loader FSM states (LOAD accepts stream words, FULL waits
//                    for a swap)
//   - kk_of        : weights per kernel for a given kernel side
//   - bank_depth   : words per bank (NUM_KERNELS * KK)
//   - clog2_min1   : index width helper that never returns zero
//   - CONV_*       : default weight width / kernel side for the conv blocks
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int CONV_DATA_WIDTH = 8;
    localparam int CONV_KSIZE      = 3;
    localparam int CONV_KK         = CONV_KSIZE * CONV_KSIZE;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } load_state_e;

    function automatic int kk_of(input int ksize);
        return ksize * ksize;
    endfunction

    function automatic int bank_depth(input int num_kernels, input int ksize);
        return num_kernels * kk_of(ksize);
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_weight_regfile.sv
// -----------------------------------------------------------------------------
// conv_weight_regfile
// Two-bank weight register file, each bank NUM_KERNELS*KK words.
// Ports:
//   clk          clock
//   wr_en_i      write strobe
//   wr_bank_i    bank written
//   wr_addr_i    word address inside the bank
//   wr_data_i    word written
//   rd_bank_i    bank read
//   rd_kernel_i  kernel index read (KK words at rd_kernel_i*KK)
//   rd_data_o    KK words, word i at [i*DATA_WIDTH +: DATA_WIDTH]; zero when
//                rd_kernel_i is out of range
// Storage is deliberately not reset.
// -----------------------------------------------------------------------------
module conv_weight_regfile
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = CONV_DATA_WIDTH,
    parameter int KSIZE       = CONV_KSIZE,
    parameter int NUM_KERNELS = 4,
    parameter int SEL_W       = clog2_min1(NUM_KERNELS),
    parameter int ADDR_W      = clog2_min1(bank_depth(NUM_KERNELS, KSIZE))
) (
    input  logic                                 clk,
    input  logic                                 wr_en_i,
    input  logic                                 wr_bank_i,
    input  logic [ADDR_W-1:0]                    wr_addr_i,
    input  logic [DATA_WIDTH-1:0]                wr_data_i,
    input  logic                                 rd_bank_i,
    input  logic [SEL_W-1:0]                     rd_kernel_i,
    output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]    rd_data_o
);

    localparam int KK    = kk_of(KSIZE);
    localparam int DEPTH = bank_depth(NUM_KERNELS, KSIZE);

    logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
    end

    // Whole-kernel parallel read; an out-of-range kernel never indexes memory.
    always_comb begin
        rd_data_o = '0;
        if (int'(rd_kernel_i) < NUM_KERNELS) begin
            for (int i = 0; i < KK; i++) begin
                rd_data_o[i*DATA_WIDTH +: DATA_WIDTH] =
                    mem_q[rd_bank_i][ADDR_W'(int'(rd_kernel_i) * KK + i)];
            end
        end
    end

endmodule

// File: rtl/convk_weight_pingpong.sv
// -----------------------------------------------------------------------------
// convk_weight_pingpong
// Double-buffered KxK convolution weight store. A serial valid/ready stream
// fills the shadow bank while the PE array reads whole kernels from the
// active bank; swap flips the bank pointer without copying data.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   valid_in      data_in carries a weight
//   ready_out     shadow bank accepts a word (registered state decode only)
//   data_in       serial weight, kernel-major then row-major
//   load_done     one-cycle pulse after the last word of a bank is accepted
//   swap          make the shadow bank active (legal only when FULL)
//   start         read request for kernel kernel_sel from the active bank
//   kernel_sel    kernel index for start
//   weights       latched kernel, weight i at [i*DATA_WIDTH +: DATA_WIDTH]
//   done          one-cycle pulse: weights updated
//   active_valid  active bank holds a complete kernel set
//   err           one-cycle pulse: illegal start or swap on the previous cycle
// -----------------------------------------------------------------------------
module convk_weight_pingpong
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = CONV_DATA_WIDTH,
    parameter int KSIZE       = CONV_KSIZE,
    parameter int NUM_KERNELS = 4,
    parameter int SEL_W       = clog2_min1(NUM_KERNELS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 valid_in,
    output logic                                 ready_out,
    input  logic [DATA_WIDTH-1:0]                data_in,
    output logic                                 load_done,
    input  logic                                 swap,
    input  logic                                 start,
    input  logic [SEL_W-1:0]                     kernel_sel,
    output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]    weights,
    output logic                                 done,
    output logic                                 active_valid,
    output logic                                 err
);

    localparam int KK    = kk_of(KSIZE);
    localparam int DEPTH = bank_depth(NUM_KERNELS, KSIZE);
    localparam int CNT_W = clog2_min1(DEPTH);
    localparam int WW    = KK * DATA_WIDTH;

    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);
    localparam logic [SEL_W:0]   NK_LIMIT  = (SEL_W + 1)'(NUM_KERNELS);

    load_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ptr_q, ptr_d;
    logic             active_valid_q, active_valid_d;
    logic [WW-1:0]    weights_q, weights_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             load_done_q, load_done_d;

    logic             accept;
    logic             wr_en;
    logic             swap_err;
    logic             sel_ok;
    logic             start_ok;
    logic [WW-1:0]    rd_data;

    conv_weight_regfile #(
        .DATA_WIDTH  (DATA_WIDTH),
        .KSIZE       (KSIZE),
        .NUM_KERNELS (NUM_KERNELS),
        .SEL_W       (SEL_W),
        .ADDR_W      (CNT_W)
    ) u_regfile (
        .clk         (clk),
        .wr_en_i     (wr_en),
        .wr_bank_i   (~ptr_q),
        .wr_addr_i   (cnt_q),
        .wr_data_i   (data_in),
        .rd_bank_i   (ptr_q),
        .rd_kernel_i (kernel_sel),
        .rd_data_o   (rd_data)
    );

    // ready depends on registered state only, never on valid_in.
    assign ready_out = (state_q == LOAD);
    assign accept    = valid_in & ready_out;

    // Loader FSM: fills the shadow bank, then waits for a swap.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ptr_d          = ptr_q;
        active_valid_d = active_valid_q;
        load_done_d    = 1'b0;
        wr_en          = 1'b0;
        swap_err       = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_d     = FULL;
                        cnt_d       = '0;
                        load_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // A swap while loading is refused, even on the final beat:
                // the bank is not complete until that edge has passed.
                if (swap) begin
                    swap_err = 1'b1;
                end
            end
            FULL: begin
                if (swap) begin
                    state_d        = LOAD;
                    ptr_d          = ~ptr_q;
                    active_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Read path uses the pre-swap pointer, so a same-cycle swap never
    // affects the kernel being read.
    always_comb begin
        sel_ok    = ({1'b0, kernel_sel} < NK_LIMIT);
        start_ok  = start & active_valid_q & sel_ok;
        weights_d = start_ok ? rd_data : weights_q;
        done_d    = start_ok;
        err_d     = swap_err | (start & ~start_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= LOAD;
            cnt_q          <= '0;
            ptr_q          <= 1'b0;
            active_valid_q <= 1'b0;
            weights_q      <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            load_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ptr_q          <= ptr_d;
            active_valid_q <= active_valid_d;
            weights_q      <= weights_d;
            done_q         <= done_d;
            err_q          <= err_d;
            load_done_q    <= load_done_d;
        end
    end

    assign weights      = weights_q;
    assign done         = done_q;
    assign err          = err_q;
    assign load_done    = load_done_q;
    assign active_valid = active_valid_q;

endmodule

// File: doc/convk_weight_pingpong.md
# convk_weight_pingpong

Parametrised, double-buffered convolution weight store. It replaces the single-kernel 3x3 weight buffer. Weights arrive serially over a valid/ready stream into a shadow bank while the compute array reads whole K×K kernels in parallel from the active bank. The block sits between the weight DMA/stream source and the convolution PE array, so the next layer's weights load with no compute stall.

## Interface
- DATA_WIDTH, 8, bits per weight
- KSIZE, 3, kernel side; KK = KSIZE*KSIZE weights per kernel
- NUM_KERNELS, 4, kernels per bank; bank depth = NUM_KERNELS*KK words
- SEL_W, $clog2(NUM_KERNELS) (min 1), kernel select width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- valid_in  in  1  data_in carries a weight
- ready_out  out  1  shadow bank accepts a word this cycle
- data_in  in  DATA_WIDTH  serial weight
- load_done  out  1  one-cycle pulse: shadow bank full
- swap  in  1  request to make the shadow bank active
- start  in  1  read request for one kernel
- kernel_sel  in  SEL_W  kernel index for start
- weights  out  KK*DATA_WIDTH  kernel weights; weight i at [i*DATA_WIDTH +: DATA_WIDTH]
- done  out  1  one-cycle pulse: weights updated
- active_valid  out  1  active bank holds a complete kernel set
- err  out  1  one-cycle pulse: illegal start or swap

## Operation
- Storage: two banks of NUM_KERNELS*KK words. Bank pointer ptr selects the active bank; the shadow bank is !ptr. Swapping toggles ptr. No data is copied.
- Load order: kernel 0 weights 0..KK-1 (row-major), then kernel 1, and so on. Shadow address = cnt.
- Loader FSM:
  - LOAD: ready_out=1. A word is accepted when valid_in && ready_out; it is written to shadow[cnt] and cnt increments. On the last word (cnt = depth-1): go to FULL, cnt←0, load_done pulses next cycle.
  - FULL: ready_out=0; valid_in is ignored. swap moves to LOAD, toggles ptr, and sets active_valid←1.
- swap in LOAD is ignored and pulses err. This includes the cycle that accepts the last word.
- Read: start with active_valid=1 and kernel_sel<NUM_KERNELS latches active[kernel_sel*KK +: KK] into weights and pulses done.
- start with active_valid=0, or with kernel_sel ≥ NUM_KERNELS: weights unchanged, no done, err pulses.
- Simultaneous start and swap: start reads the pre-swap active bank. The swap takes effect the following cycle.
- Loading and reading are fully concurrent. Shadow writes never alter weights.
- weights holds its value until the next accepted start.
- Reset values: ptr=0, cnt=0, FSM=LOAD, ready_out=1 from the first cycle after reset, active_valid=0, weights=0, done=0, err=0, load_done=0. Bank storage is not reset.
- Reset mid-load discards the partial load (cnt=0). A previously active set is invalidated (active_valid=0).

## Timing
- ready_out is decoded from registered FSM state only. It has no combinational path from valid_in.
- Throughput is one weight per cycle. A full bank needs NUM_KERNELS*KK accepted beats. load_done is asserted one cycle after the last accepting edge.
- Start latency is 1. Start sampled at edge n gives weights and done valid after edge n, for one cycle. Back-to-back starts give back-to-back done pulses.
- swap accepted at edge n: the new bank is readable by a start sampled at edge n+1. ready_out=1 after edge n.
- err is a registered pulse, asserted the cycle after the offending request.

## Structure
- Package conv_pkg holds:
  - the loader state enum {LOAD, FULL};
  - a helper function for KK and bank depth;
  - shared weight-width constants for the conv blocks.
- Sub-module conv_weight_regfile: 2×NUM_KERNELS*KK word register file with one write port (bank, addr, data) and one KK-wide read port (bank, kernel). convk_weight_pingpong contains the FSM, pointer, handshake and output registers.

## Test plan
All scenarios use DATA_WIDTH=8, KSIZE=3, NUM_KERNELS=2 (bank depth 18).
- Reset, stream 1..18 continuously: ready_out falls after the 18th beat and load_done pulses once. A start before any swap gives err=1, no done, weights=0.
- Then swap, then start with kernel_sel=1: one cycle later done=1 and weights bytes 0..8 = 10..18. A start with kernel_sel=0 gives 1..9.
- Stream 101..118 with random valid gaps while issuing starts every cycle: outputs stay 1..9 / 10..18. A 19th word held with valid_in=1 is not accepted while FULL. After swap, kernel_sel=0 gives 101..109.
- Same-cycle start(kernel_sel=0) and swap: the output is the pre-swap kernel 0. The next start(kernel_sel=0) returns the post-swap kernel 0. swap issued in LOAD after 5 words gives err, and ptr is unchanged.
- Reset asserted after 7 words of a load: ready_out=1, active_valid=0, weights=0. A fresh 18-word load plus swap then reads correctly.
- NUM_KERNELS=3 build: start with kernel_sel=3 gives err and no done.
